// File: rtl/alarm_siren_controller.sv
// Vehicle-alarm FSM: arm delay, entry countdown and siren duration,
// with a 2 Hz strobe. Optional macro: ARM_ON_IGNITION_OFF_EN.
module alarm_siren_controller #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned T_ARM_S   = 6,
  parameter int unsigned T_DELAY_S = 8,
  parameter int unsigned T_ALARM_S = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       arm,
  input  logic       disarm,
  input  logic       door_open,
  input  logic       ignition,
  output logic       enable_siren,
  output logic       two_hz_enable,
  output logic       status_led,
  output logic [2:0] state
);

  localparam logic [2:0] S_DISARMED  = 3'd0;
  localparam logic [2:0] S_ARMING    = 3'd1;
  localparam logic [2:0] S_ARMED     = 3'd2;
  localparam logic [2:0] S_TRIGGERED = 3'd3;
  localparam logic [2:0] S_ALARM     = 3'd4;

  localparam int unsigned HALF = CLK_HZ / 2;
  localparam int unsigned DW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam int unsigned MAXT_A =
    (T_ARM_S > T_DELAY_S) ? T_ARM_S : T_DELAY_S;
  localparam int unsigned MAXT =
    (MAXT_A > T_ALARM_S) ? MAXT_A : T_ALARM_S;
  localparam int unsigned MAX_CYC = MAXT * CLK_HZ;
  localparam int unsigned TW = $clog2(MAX_CYC);

  localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);
  localparam logic [TW-1:0] LD_ARM   = TW'(T_ARM_S * CLK_HZ - 1);
  localparam logic [TW-1:0] LD_DLY   = TW'(T_DELAY_S * CLK_HZ - 1);
  localparam logic [TW-1:0] LD_ALM   = TW'(T_ALARM_S * CLK_HZ - 1);

  logic [DW-1:0] div_q, div_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    st_q, st_d;
  logic          led_q, led_d;
  logic          hz_q;
  logic          siren_q;
  logic          arm_ev;
  logic          expired;

`ifdef ARM_ON_IGNITION_OFF_EN
  logic ign_q;

  // Previous ignition level for falling-edge arming
  always_ff @(posedge clock) begin
    if (reset) ign_q <= 1'b0;
    else       ign_q <= ignition;
  end

  assign arm_ev = arm | (ign_q & ~ignition);
`else
  assign arm_ev = arm;
`endif

  assign expired = (tmr_q == '0);

  // Free-running half-second divider
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
  end

  // Next state, timer and LED
  always_comb begin
    st_d  = st_q;
    tmr_d = expired ? '0 : tmr_q - TW'(1);
    led_d = led_q;
    if (disarm) begin
      st_d = S_DISARMED;
    end else begin
      unique case (st_q)
        S_DISARMED: begin
          if (arm_ev && !door_open) begin
            st_d  = S_ARMING;
            tmr_d = LD_ARM;
          end
        end
        S_ARMING: begin
          if (door_open)    tmr_d = LD_ARM;
          else if (expired) st_d  = S_ARMED;
        end
        S_ARMED: begin
          if (door_open || ignition) begin
            st_d  = S_TRIGGERED;
            tmr_d = LD_DLY;
          end
        end
        S_TRIGGERED: begin
          if (expired) begin
            st_d  = S_ALARM;
            tmr_d = LD_ALM;
          end
        end
        S_ALARM: begin
          if (expired) begin
            if (!door_open && !ignition) st_d  = S_ARMED;
            else                         tmr_d = LD_ALM;
          end
        end
        default: st_d = S_DISARMED;
      endcase
    end
    if (st_d == S_ARMED) begin
      if (st_q != S_ARMED) led_d = 1'b0;
      else if (hz_q)       led_d = ~led_q;
    end else begin
      led_d = (st_d != S_DISARMED);
    end
  end

  // State, timer and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q   <= '0;
      tmr_q   <= '0;
      st_q    <= S_DISARMED;
      led_q   <= 1'b0;
      hz_q    <= 1'b0;
      siren_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      tmr_q   <= tmr_d;
      st_q    <= st_d;
      led_q   <= led_d;
      hz_q    <= (div_q == DIV_LAST);
      siren_q <= (st_d == S_ALARM);
    end
  end

  assign state         = st_q;
  assign enable_siren  = siren_q;
  assign two_hz_enable = hz_q;
  assign status_led    = led_q;

endmodule

// File: tb/tb_alarm_siren_controller.sv
// Bench for alarm_siren_controller: deadline-based reference model
// checked every cycle, plus literal expectations at key cycles.
module tb_alarm_siren_controller;

  localparam int CLK_HZ    = 8;
  localparam int T_ARM_S   = 2;
  localparam int T_DELAY_S = 3;
  localparam int T_ALARM_S = 4;
  localparam int HALF      = CLK_HZ / 2;
  localparam int D_ARM     = T_ARM_S * CLK_HZ;
  localparam int D_DLY     = T_DELAY_S * CLK_HZ;
  localparam int D_ALM     = T_ALARM_S * CLK_HZ;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       arm = 1'b0;
  logic       disarm = 1'b0;
  logic       door_open = 1'b0;
  logic       ignition = 1'b0;
  logic       enable_siren;
  logic       two_hz_enable;
  logic       status_led;
  logic [2:0] state;

  alarm_siren_controller #(
    .CLK_HZ   (CLK_HZ),
    .T_ARM_S  (T_ARM_S),
    .T_DELAY_S(T_DELAY_S),
    .T_ALARM_S(T_ALARM_S)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .arm          (arm),
    .disarm       (disarm),
    .door_open    (door_open),
    .ignition     (ignition),
    .enable_siren (enable_siren),
    .two_hz_enable(two_hz_enable),
    .status_led   (status_led),
    .state        (state)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int tcyc    = 0;
  int base    = 0;

  // Reference model: mode plus absolute deadline cycle
  int   cyc = 0;
  int   m_st = 0;
  int   m_end = 0;
  int   m_led = 0;
  int   m_strobe = 0;
  bit   m_ign = 1'b0;
  bit   m_valid = 1'b0;
  int   p;
  int   ns;
  bit   arm_ev;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               name, act, exp, tcyc - base);
    end
  endtask

  always @(posedge clock) begin
    tcyc++;
    if (reset) begin
      cyc      = 0;
      m_st     = 0;
      m_led    = 0;
      m_strobe = 0;
      m_end    = 0;
      m_valid  = 1'b1;
      m_ign    = 1'b0;
    end else begin
      p   = cyc;
      cyc = cyc + 1;
      arm_ev = arm;
`ifdef ARM_ON_IGNITION_OFF_EN
      arm_ev = arm || (m_ign && !ignition);
`endif
      ns = m_st;
      if (disarm) ns = 0;
      else begin
        case (m_st)
          0: if (arm_ev && !door_open) begin
               ns = 1; m_end = p + D_ARM;
             end
          1: if (door_open) m_end = p + D_ARM;
             else if (p == m_end) ns = 2;
          2: if (door_open || ignition) begin
               ns = 3; m_end = p + D_DLY;
             end
          3: if (p == m_end) begin
               ns = 4; m_end = p + D_ALM;
             end
          4: if (p == m_end) begin
               if (!door_open && !ignition) ns = 2;
               else m_end = p + D_ALM;
             end
          default: ns = 0;
        endcase
      end
      if (ns == 2) m_led = (m_st == 2) ? (m_led ^ m_strobe) : 0;
      else         m_led = (ns != 0) ? 1 : 0;
      m_st     = ns;
      m_strobe = (cyc % HALF == 0) ? 1 : 0;
      m_ign    = ignition;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (m_valid) begin
      check("state", 32'(state), 32'(m_st));
      check("siren", 32'(enable_siren), (m_st == 4) ? 1 : 0);
      check("two_hz", 32'(two_hz_enable), 32'(m_strobe));
      check("led", 32'(status_led), 32'(m_led));
    end
  end

  task automatic at(input int k);
    while (tcyc - base < k) @(negedge clock);
    #1;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    base  = tcyc;
    reset = 1'b0;
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_siren", 32'(enable_siren), 0);
    check("rst_led", 32'(status_led), 0);
    check("rst_hz", 32'(two_hz_enable), 0);
    at(3);  check("hz_c3", 32'(two_hz_enable), 0);
    at(4);  check("hz_c4", 32'(two_hz_enable), 1);
    at(5);  check("hz_c5", 32'(two_hz_enable), 0);
    at(8);  check("hz_c8", 32'(two_hz_enable), 1);
    at(10); arm = 1'b1;
    at(11); arm = 1'b0;
    check("arming_c11", 32'(state), 1);
    at(12); check("hz_c12", 32'(two_hz_enable), 1);
    at(26); check("arming_c26", 32'(state), 1);
    at(27); check("armed_c27", 32'(state), 2);
    check("led_c27", 32'(status_led), 0);
    at(29); check("led_c29", 32'(status_led), 1);
    at(33); check("led_c33", 32'(status_led), 0);
    at(40); door_open = 1'b1;
    at(41); door_open = 1'b0;
    check("trig_c41", 32'(state), 3);
    at(64); check("trig_c64", 32'(state), 3);
    at(65); check("alarm_c65", 32'(state), 4);
    check("siren_c65", 32'(enable_siren), 1);
    at(96); check("alarm_c96", 32'(state), 4);
    at(97); check("armed_c97", 32'(state), 2);
    check("siren_c97", 32'(enable_siren), 0);
    at(100); door_open = 1'b1;
    at(101); door_open = 1'b0;
    at(150); door_open = 1'b1;
    at(156); check("alarm_c156", 32'(state), 4);
    at(157); check("reload_c157", 32'(state), 4);
    check("siren_c157", 32'(enable_siren), 1);
    at(161); door_open = 1'b0;
    at(170); disarm = 1'b1;
    at(171); disarm = 1'b0;
    check("dis_state", 32'(state), 0);
    check("dis_siren", 32'(enable_siren), 0);
    check("dis_led", 32'(status_led), 0);
    at(180); arm = 1'b1;
    at(181); arm = 1'b0;
    at(185); door_open = 1'b1;
    at(188); door_open = 1'b0;
    at(203); check("arming_c203", 32'(state), 1);
    at(204); check("armed_c204", 32'(state), 2);
    at(210); disarm = 1'b1;
    at(211); disarm = 1'b0;
    at(215); arm = 1'b1; disarm = 1'b1;
    at(216); arm = 1'b0; disarm = 1'b0;
    check("arm_dis_c216", 32'(state), 0);
    at(220); arm = 1'b1; door_open = 1'b1;
    at(221); arm = 1'b0; door_open = 1'b0;
    check("arm_door_c221", 32'(state), 0);
    at(225); ignition = 1'b1;
    at(230); ignition = 1'b0;
    at(231);
`ifdef ARM_ON_IGNITION_OFF_EN
    check("ign_arm_c231", 32'(state), 1);
`else
    check("ign_arm_c231", 32'(state), 0);
`endif
    at(240); disarm = 1'b1;
    at(241); disarm = 1'b0;
    check("dis_c241", 32'(state), 0);
    at(250); arm = 1'b1;
    at(251); arm = 1'b0;
    at(267); check("armed_c267", 32'(state), 2);
    at(270); door_open = 1'b1;
    at(271); door_open = 1'b0;
    at(299); check("alarm_c299", 32'(state), 4);
    check("siren_c299", 32'(enable_siren), 1);
    at(300); reset = 1'b1;
    at(301);
    check("mrst_state", 32'(state), 0);
    check("mrst_siren", 32'(enable_siren), 0);
    check("mrst_led", 32'(status_led), 0);
    reset = 1'b0;
    at(304); check("mrst_hz3", 32'(two_hz_enable), 0);
    at(305); check("mrst_hz4", 32'(two_hz_enable), 1);
    at(310);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
